lcd_scan: RTL and testbench

- Read side of the Z88 LCD nibble frame buffer; the screen renderer is the write side.
- Generates 640x480 VGA-style timing and fetches 4-pixel nibbles from the VRAM read port.
- Serialises the nibbles MSB-first and outputs the 640x64 Z88 screen scaled vertically inside a bordered window.

---
 rtl/z88_lcd_pkg.sv | 28 ++
 rtl/lcd_timing.sv | 88 ++++++++
 rtl/lcd_scan.sv | 161 ++++++++++++++++
 tb/tb_lcd_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/z88_lcd_pkg.sv
// +----------------------------------------------------------------------------+
// | z88_lcd_pkg : shared constants for the Z88 LCD nibble frame buffer         |
// |               (geometry, VRAM address map, RGB444 palette)                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package z88_lcd_pkg;
   localparam int LCD_LINES   = 64;
   localparam int LCD_NIBBLES = 160;
   localparam int VRAM_AW     = 14;

   // vram_a = {line, nibble column}; renderer and scanner must agree on this split
   localparam int VA_COL_W  = 8;
   localparam int VA_LINE_W = 6;

   localparam logic [11:0] RGB_BLANK  = 12'h000;
   localparam logic [11:0] RGB_BORDER = 12'h333;
   localparam logic [11:0] RGB_DOT    = 12'h1F2;
   localparam logic [11:0] RGB_BG     = 12'hCDB;

   function automatic logic [VRAM_AW-1:0] vram_addr(input logic [VA_LINE_W-1:0] line,
                                                     input logic [VA_COL_W-1:0]  col);
      return {line, col};
   endfunction
endpackage

`default_nettype wire

// File: rtl/lcd_timing.sv
// +----------------------------------------------------------------------------+
// | lcd_timing : VGA-style raster counters with registered syncs, de and sof   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int HCW      = 10,
   parameter int VCW      = 10
) (
   input  logic           mck,
   input  logic           rin,
   input  logic           i_pix_ce,
   output logic [HCW-1:0] o_hcnt,
   output logic [VCW-1:0] o_vcnt,
   output logic           o_line_end,
   output logic           o_vis,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_de,
   output logic           o_sof
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HCW-1:0] c_H_LAST = HCW'(H_TOTAL - 1);
   localparam logic [HCW-1:0] c_H_ACT  = HCW'(H_ACTIVE);
   localparam logic [HCW-1:0] c_HS_BEG = HCW'(H_ACTIVE + H_FP);
   localparam logic [HCW-1:0] c_HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCW-1:0] c_V_LAST = VCW'(V_TOTAL - 1);
   localparam logic [VCW-1:0] c_V_ACT  = VCW'(V_ACTIVE);
   localparam logic [VCW-1:0] c_VS_BEG = VCW'(V_ACTIVE + V_FP);
   localparam logic [VCW-1:0] c_VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic           c_SYNC_ON = (SYNC_POL != 0);

   logic [HCW-1:0] r_hcnt;
   logic [VCW-1:0] r_vcnt;
   logic           r_hsync, r_vsync, r_de, r_sof;
   logic           w_line_end, w_vis, w_hs, w_vs;

   always_comb begin
      w_line_end = (r_hcnt == c_H_LAST);
      w_vis      = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
      w_hs       = (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END);
      w_vs       = (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END);
   end

   // Outputs describe the current count, so they trail it by one pixel
   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         r_hcnt  <= '0;
         r_vcnt  <= '0;
         r_hsync <= !c_SYNC_ON;
         r_vsync <= !c_SYNC_ON;
         r_de    <= 1'b0;
         r_sof   <= 1'b0;
      end else if (i_pix_ce) begin
         r_hcnt <= w_line_end ? '0 : r_hcnt + 1'b1;
         if (w_line_end) begin
            r_vcnt <= (r_vcnt == c_V_LAST) ? '0 : r_vcnt + 1'b1;
         end
         r_hsync <= w_hs ? c_SYNC_ON : !c_SYNC_ON;
         r_vsync <= w_vs ? c_SYNC_ON : !c_SYNC_ON;
         r_de    <= w_vis;
         r_sof   <= (r_hcnt == '0) && (r_vcnt == '0);
      end
   end

   assign o_hcnt     = r_hcnt;
   assign o_vcnt     = r_vcnt;
   assign o_line_end = w_line_end;
   assign o_vis      = w_vis;
   assign o_hsync    = r_hsync;
   assign o_vsync    = r_vsync;
   assign o_de       = r_de;
   assign o_sof      = r_sof;
endmodule

`default_nettype wire

// File: rtl/lcd_scan.sv
// +----------------------------------------------------------------------------+
// | lcd_scan : Z88 LCD frame-buffer scanner - fetches VRAM nibbles, serialises |
// |            them and places the 640x64 screen in a scaled window.           |
// |            Optional RGB444 output enabled by macro LCD_SCAN_RGB_EN.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_scan
   import z88_lcd_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_SCALE  = 7,
   parameter int V_OFFSET = 16,
   parameter int SYNC_POL = 0
) (
   input  logic               mck,
   input  logic               rin,
   input  logic               pix_ce,
   input  logic               lcdon,
   output logic [VRAM_AW-1:0] vram_a,
   output logic               vram_re,
   input  logic [3:0]         vram_di,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               pix,
`ifdef LCD_SCAN_RGB_EN
   output logic [11:0]        rgb,
`endif
   output logic               sof
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HCW     = $clog2(H_TOTAL);
   localparam int VCW     = $clog2(V_TOTAL);
   localparam int ZSW     = $clog2(V_SCALE + 1);
   localparam int N_COLS  = (H_ACTIVE / 4 < LCD_NIBBLES) ? H_ACTIVE / 4 : LCD_NIBBLES;

   localparam logic [HCW-1:0] c_H_PREFETCH   = HCW'(H_TOTAL - 4);
   localparam logic [HCW-1:0] c_H_FETCH_LAST = HCW'(4 * N_COLS - 8);
   localparam logic [VCW-1:0] c_V_LAST       = VCW'(V_TOTAL - 1);
   localparam logic [VCW-1:0] c_WIN_PRE      = VCW'(V_OFFSET - 1);
   localparam logic [VCW-1:0] c_WIN_FIRST    = VCW'(V_OFFSET);
   localparam logic [VCW-1:0] c_WIN_LAST     = VCW'(V_OFFSET + LCD_LINES * V_SCALE - 1);
   localparam logic [ZSW-1:0] c_ZSUB_LAST    = ZSW'(V_SCALE - 1);

   logic [HCW-1:0]       w_hcnt;
   logic [VCW-1:0]       w_vcnt, w_vnext;
   logic                 w_line_end, w_vis;
   logic                 w_in_win, w_next_in_win, w_prefetch, w_fetch_col, w_fetch;
   logic [VA_LINE_W-1:0] w_zline_next, w_line;
   logic [VA_COL_W-1:0]  w_col;

   logic [VA_LINE_W-1:0] r_zline;
   logic [ZSW-1:0]       r_zsub;
   logic                 r_vram_re, r_pix;
   logic [VRAM_AW-1:0]   r_vram_a;
   logic [3:0]           r_nib, r_shift;

   lcd_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .SYNC_POL (SYNC_POL), .HCW (HCW), .VCW (VCW)
   ) u_timing (
      .mck        (mck),
      .rin        (rin),
      .i_pix_ce   (pix_ce),
      .o_hcnt     (w_hcnt),
      .o_vcnt     (w_vcnt),
      .o_line_end (w_line_end),
      .o_vis      (w_vis),
      .o_hsync    (hsync),
      .o_vsync    (vsync),
      .o_de       (de),
      .o_sof      (sof)
   );

   always_comb begin
      w_vnext       = (w_vcnt == c_V_LAST) ? '0 : w_vcnt + 1'b1;
      w_in_win      = (w_vcnt >= c_WIN_FIRST) && (w_vcnt <= c_WIN_LAST);
      w_next_in_win = (w_vnext >= c_WIN_FIRST) && (w_vnext <= c_WIN_LAST);
      w_zline_next  = r_zline;
      if (w_vcnt == c_WIN_PRE) begin
         w_zline_next = '0;
      end else if (w_in_win && (r_zsub == c_ZSUB_LAST)) begin
         w_zline_next = r_zline + 1'b1;
      end
      // Column 0 is fetched at the tail of the previous line, so it needs that line's successor zline
      w_prefetch  = (w_hcnt == c_H_PREFETCH) && w_next_in_win;
      w_fetch_col = (w_hcnt[1:0] == 2'd0) && (w_hcnt <= c_H_FETCH_LAST) && w_in_win;
      w_fetch     = pix_ce && lcdon && (w_prefetch || w_fetch_col);
      w_col       = w_prefetch ? '0 : VA_COL_W'(w_hcnt[HCW-1:2]) + 1'b1;
      w_line      = w_prefetch ? w_zline_next : r_zline;
   end

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         r_zline   <= '0;
         r_zsub    <= '0;
         r_vram_re <= 1'b0;
         r_vram_a  <= '0;
         r_nib     <= '0;
         r_shift   <= '0;
         r_pix     <= 1'b0;
      end else begin
         r_vram_re <= w_fetch;
         if (w_fetch) begin
            r_vram_a <= vram_addr(w_line, w_col);
         end
         if (r_vram_re) begin
            r_nib <= vram_di;
         end
         if (pix_ce) begin
            if (w_line_end) begin
               r_zline <= w_zline_next;
               if ((w_vcnt == c_WIN_PRE) || (w_in_win && (r_zsub == c_ZSUB_LAST))) begin
                  r_zsub <= '0;
               end else if (w_in_win) begin
                  r_zsub <= r_zsub + 1'b1;
               end
            end
            r_shift <= (w_hcnt[1:0] == 2'd3) ? r_nib : {r_shift[2:0], 1'b0};
            r_pix   <= r_shift[3] && w_vis && w_in_win && lcdon;
         end
      end
   end

   assign vram_a  = r_vram_a;
   assign vram_re = r_vram_re;
   assign pix     = r_pix;

`ifdef LCD_SCAN_RGB_EN
   logic [11:0] r_rgb;

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         r_rgb <= RGB_BLANK;
      end else if (pix_ce) begin
         if (!w_vis) begin
            r_rgb <= RGB_BLANK;
         end else if (!w_in_win || !lcdon) begin
            r_rgb <= RGB_BORDER;
         end else begin
            r_rgb <= r_shift[3] ? RGB_DOT : RGB_BG;
         end
      end
   end

   assign rgb = r_rgb;
`endif
endmodule

`default_nettype wire

// File: tb/tb_lcd_scan.sv
// +----------------------------------------------------------------------------+
// | tb_lcd_scan : self-checking bench for lcd_scan on a reduced raster         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_scan;
   // Reduced raster keeps a whole frame short while preserving the nibble/line map
   localparam int HA = 32, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 134, VFP = 2, VS_W = 2, VBP = 3;
   localparam int VSC = 2, VO = 3;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS_W + VBP;
   localparam int WIN_END = VO + 64 * VSC;
   localparam int FETCH_PER_FRAME = 64 * VSC * (HA / 4);

   typedef logic [4:0] outv_t;   // {hsync, vsync, de, pix, sof}

   logic        mck = 1'b0;
   logic        rin, pix_ce, lcdon;
   logic [13:0] vram_a;
   logic        vram_re;
   logic [3:0]  vram_di;
   logic        hsync, vsync, de, pix, sof;
`ifdef LCD_SCAN_RGB_EN
   logic [11:0] rgb;
`endif

   logic [3:0] mem [0:16383];
   assign vram_di = mem[vram_a];

   always #5 mck = ~mck;

   lcd_scan #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS_W), .V_BP (VBP),
      .V_SCALE (VSC), .V_OFFSET (VO), .SYNC_POL (0)
   ) dut (
      .mck     (mck),
      .rin     (rin),
      .pix_ce  (pix_ce),
      .lcdon   (lcdon),
      .vram_a  (vram_a),
      .vram_re (vram_re),
      .vram_di (vram_di),
      .hsync   (hsync),
      .vsync   (vsync),
      .de      (de),
      .pix     (pix),
`ifdef LCD_SCAN_RGB_EN
      .rgb     (rgb),
`endif
      .sof     (sof)
   );

   outv_t      q_exp[$];
   outv_t      exp_last;
   int         n_cmp = 0, n_err = 0;
   int         m_h, m_v, cur_h, cur_v;
   int         fetch_cnt, sof_cnt;
   logic [3:0] c_first, c_last;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (line %0d px %0d)", tag, got, exp, cur_v, cur_h);
      end
   endtask

   function automatic bit in_win(input int v);
      return (v >= VO) && (v < WIN_END);
   endfunction

   function automatic outv_t model(input int h, input int v, input logic lon);
      logic       hs_e, vs_e, de_e, px_e, sf_e;
      logic [3:0] nib;
      hs_e = !((h >= HA + HFP) && (h < HA + HFP + HS));
      vs_e = !((v >= VA + VFP) && (v < VA + VFP + VS_W));
      de_e = (h < HA) && (v < VA);
      px_e = 1'b0;
      if (de_e && lon && in_win(v)) begin
         nib  = mem[((v - VO) / VSC) * 256 + h / 4];
         px_e = nib[3 - h % 4];
      end
      sf_e = (h == 0) && (v == 0);
      return {hs_e, vs_e, de_e, px_e, sf_e};
   endfunction

   // Address of the read the pixel at (h, v) must launch, or -1 for none
   function automatic int exp_fetch(input int h, input int v, input logic lon);
      int vn;
      vn = (v + 1) % VT;
      if (!lon) return -1;
      if (h == HT - 4 && in_win(vn)) return ((vn - VO) / VSC) * 256;
      if (h % 4 == 0 && h / 4 + 1 < HA / 4 && in_win(v)) return ((v - VO) / VSC) * 256 + h / 4 + 1;
      return -1;
   endfunction

   task automatic step(input logic ce);
      outv_t e;
      int    fa;
      pix_ce = ce;
      fa     = -1;
      if (ce) begin
         e     = model(m_h, m_v, lcdon);
         fa    = exp_fetch(m_h, m_v, lcdon);
         cur_h = m_h;
         cur_v = m_v;
         m_h++;
         if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v + 1) % VT;
         end
      end else begin
         e = exp_last;
      end
      q_exp.push_back(e);
      exp_last = e;
      @(posedge mck);
      #1;
      chk("outs", {hsync, vsync, de, pix, sof}, q_exp.pop_front());
      chk("vram_re", vram_re, fa >= 0);
      if (fa >= 0) chk("vram_a", vram_a, fa);
      if (vram_re) fetch_cnt++;
      if (ce && sof) sof_cnt++;
      if (ce && cur_v == VO && cur_h < 4)
         chk("map_first", pix, c_first[3 - cur_h]);
      if (ce && cur_v >= WIN_END - VSC && cur_v < WIN_END && cur_h >= HA - 4 && cur_h < HA)
         chk("map_last", pix, c_last[3 - (cur_h - (HA - 4))]);
      if (ce && (cur_v == VO - 1 || cur_v == WIN_END) && cur_h < HA)
         chk("outside_win", pix, 1'b0);
   endtask

   task automatic run_to(input int v, input int h);
      while (!(m_v == v && m_h == h)) step(1'b1);
   endtask

   initial begin
      rin     = 1'b1;
      pix_ce  = 1'b0;
      lcdon   = 1'b1;
      c_first = 4'hA;
      c_last  = 4'h1;
      for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom);
      mem[0]          = c_first;
      mem[63*256 + 7] = c_last;
      cur_h = 0;
      cur_v = 0;
      repeat (3) @(posedge mck);
      #1;
      chk("rst_outs", {hsync, vsync, de, pix, sof}, 5'b11000);
      chk("rst_vram_re", vram_re, 1'b0);
      chk("rst_vram_a", vram_a, 14'd0);
      rin      = 1'b0;
      m_h      = 0;
      m_v      = 0;
      exp_last = 5'b11000;

      // Full-rate frame
      fetch_cnt = 0;
      sof_cnt   = 0;
      repeat (HT * VT) step(1'b1);
      chk("fetch_frame_full", fetch_cnt, FETCH_PER_FRAME);
      chk("sof_frame_full", sof_cnt, 1);

      // Pixel enable every third clock
      fetch_cnt = 0;
      sof_cnt   = 0;
      for (int i = 0; i < 3 * HT * VT; i++) step(i % 3 == 0);
      chk("fetch_frame_slow", fetch_cnt, FETCH_PER_FRAME);
      chk("sof_frame_slow", sof_cnt, 1);

      // LCD switched off mid-line, back on before the next line's prefetch
      run_to(40, 18);
      lcdon     = 1'b0;
      fetch_cnt = 0;
      run_to(41, 40);
      chk("fetch_lcd_off", fetch_cnt, 0);
      lcdon = 1'b1;

      // Asynchronous reset mid-frame
      run_to(60, 10);
      #2;
      rin    = 1'b1;
      pix_ce = 1'b0;
      #1;
      chk("rst_async_outs", {hsync, vsync, de, pix, sof}, 5'b11000);
      chk("rst_async_vram_re", vram_re, 1'b0);
      chk("rst_async_vram_a", vram_a, 14'd0);
      repeat (2) @(posedge mck);
      #1;
      rin       = 1'b0;
      m_h       = 0;
      m_v       = 0;
      exp_last  = 5'b11000;
      fetch_cnt = 0;
      sof_cnt   = 0;
      repeat (HT * VT) step(1'b1);
      chk("fetch_after_rst", fetch_cnt, FETCH_PER_FRAME);
      chk("sof_after_rst", sof_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
